// File: rtl/match_session_fsm.sv
// Multiplayer session controller for N_OPP opponent links.
// Tracks game start/end synchronisation per opponent, drives handshake request
// flags to the link senders and reports session status to game logic/display.
// Ready, lost and won phases are bounded by on-chip cycle counters.
//
// Ports:
//   clk, rst_l          clock, asynchronous active-low reset
//   player_ready        player initiates a multiplayer game
//   player_unready      player cancels before the game starts
//   top_out             local player lost
//   ack_received[N]     per-opponent ACK from the link receivers (level or pulse)
//   opp_lost[N]         per-opponent game-lost indication from the link receivers
//   send_ready          request ACK on all handshake lines
//   send_game_lost      request GAME END on all handshake lines
//   game_active         any state but IDLE
//   gameready/ingame/gamelost/gamewon  one-hot state status
//   opp_alive[N]        opponents not yet seen losing
//   ready_timeout       one-cycle pulse when the ready phase is abandoned by timeout
module match_session_fsm #(
    parameter int unsigned N_OPP                = 1,
    parameter int unsigned READY_TIMEOUT_CYCLES = 0,
    parameter int unsigned LOST_TIMEOUT_CYCLES  = 0,
    parameter int unsigned WIN_TIMEOUT_CYCLES   = 1024
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             player_ready,
    input  logic             player_unready,
    input  logic             top_out,
    input  logic [N_OPP-1:0] ack_received,
    input  logic [N_OPP-1:0] opp_lost,
    output logic             send_ready,
    output logic             send_game_lost,
    output logic             game_active,
    output logic             gameready,
    output logic             ingame,
    output logic             gamelost,
    output logic             gamewon,
    output logic [N_OPP-1:0] opp_alive,
    output logic             ready_timeout
);

    localparam int unsigned MAX_RL = (READY_TIMEOUT_CYCLES > LOST_TIMEOUT_CYCLES) ?
                                     READY_TIMEOUT_CYCLES : LOST_TIMEOUT_CYCLES;
    localparam int unsigned MAX_T  = (MAX_RL > WIN_TIMEOUT_CYCLES) ? MAX_RL : WIN_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W  = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

    // Last count value of each phase; a timeout of T fires at count T-1.
    localparam int unsigned READY_LAST_I = (READY_TIMEOUT_CYCLES == 0) ? 0 : READY_TIMEOUT_CYCLES - 1;
    localparam int unsigned LOST_LAST_I  = (LOST_TIMEOUT_CYCLES == 0)  ? 0 : LOST_TIMEOUT_CYCLES - 1;
    localparam int unsigned WIN_LAST_I   = (WIN_TIMEOUT_CYCLES == 0)   ? 0 : WIN_TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_LAST_I);
    localparam logic [CNT_W-1:0] LOST_LAST  = CNT_W'(LOST_LAST_I);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_LAST_I);
    localparam logic READY_TO_EN = (READY_TIMEOUT_CYCLES != 0);
    localparam logic LOST_TO_EN  = (LOST_TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READY    = 3'd1,
        S_IN_GAME  = 3'd2,
        S_LOST     = 3'd3,
        S_WON      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [N_OPP-1:0]   ack_seen_q, ack_seen_d;
    logic [N_OPP-1:0]   lost_seen_q, lost_seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_timeout_d;
    logic               send_ready_d, send_game_lost_d, game_active_d;
    logic               gameready_d, ingame_d, gamelost_d, gamewon_d;

    logic [N_OPP-1:0]   ack_now, lost_now;
    logic               all_ack, all_lost, all_done;
    logic               state_change;

    // Sticky history merged with same-cycle arrivals so a late bit still counts.
    always_comb begin
        ack_now  = ack_seen_q | ack_received;
        lost_now = lost_seen_q | opp_lost;
        all_ack  = &ack_now;
        all_lost = &lost_now;
        all_done = &(ack_now | lost_now);
    end

    // Next state, counters, sticky registers and output decode of the next state.
    always_comb begin
        state_d         = state_q;
        ready_timeout_d = 1'b0;
        cnt_d           = cnt_q;
        ack_seen_d      = ack_seen_q;
        lost_seen_d     = lost_seen_q;

        case (state_q)
            S_IDLE: begin
                if (player_ready) state_d = S_READY;
            end
            S_READY: begin
                if (player_unready) begin
                    state_d = S_IDLE;
                end else if (all_ack) begin
                    state_d = S_IN_GAME;
                end else if (READY_TO_EN && (cnt_q == READY_LAST)) begin
                    state_d         = S_IDLE;
                    ready_timeout_d = 1'b1;
                end
            end
            S_IN_GAME: begin
                // A simultaneous win takes precedence over the local top-out.
                if (all_lost)     state_d = S_WON;
                else if (top_out) state_d = S_LOST;
            end
            S_LOST: begin
                // Opponents already out cannot ACK, so their loss stands in for it.
                if (all_done)                                    state_d = S_IDLE;
                else if (LOST_TO_EN && (cnt_q == LOST_LAST))     state_d = S_IDLE;
            end
            S_WON: begin
                if (cnt_q == WIN_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        state_change = (state_d != state_q);

        // Phase counter: restarts on every state change, runs only in timed phases.
        if (state_change) begin
            cnt_d = '0;
        end else if ((state_q == S_READY) || (state_q == S_LOST) || (state_q == S_WON)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_change) begin
            ack_seen_d = '0;
        end else if ((state_q == S_READY) || (state_q == S_LOST)) begin
            ack_seen_d = ack_seen_q | ack_received;
        end

        // Loss history survives the return to IDLE so the display keeps the result.
        if ((state_d == S_READY) && (state_q != S_READY)) begin
            lost_seen_d = '0;
        end else if ((state_q == S_IN_GAME) || (state_q == S_LOST)) begin
            lost_seen_d = lost_seen_q | opp_lost;
        end

        game_active_d    = (state_d != S_IDLE);
        gameready_d      = (state_d == S_READY);
        ingame_d         = (state_d == S_IN_GAME);
        gamelost_d       = (state_d == S_LOST);
        gamewon_d        = (state_d == S_WON);
        // WON keeps ACKing so the last opponent's GAME END is acknowledged.
        send_ready_d     = (state_d == S_READY) || (state_d == S_WON);
        send_game_lost_d = (state_d == S_LOST);
    end

    // State, sticky and output registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q        <= S_IDLE;
            ack_seen_q     <= '0;
            lost_seen_q    <= '0;
            cnt_q          <= '0;
            ready_timeout  <= 1'b0;
            send_ready     <= 1'b0;
            send_game_lost <= 1'b0;
            game_active    <= 1'b0;
            gameready      <= 1'b0;
            ingame         <= 1'b0;
            gamelost       <= 1'b0;
            gamewon        <= 1'b0;
            opp_alive      <= '1;
        end else begin
            state_q        <= state_d;
            ack_seen_q     <= ack_seen_d;
            lost_seen_q    <= lost_seen_d;
            cnt_q          <= cnt_d;
            ready_timeout  <= ready_timeout_d;
            send_ready     <= send_ready_d;
            send_game_lost <= send_game_lost_d;
            game_active    <= game_active_d;
            gameready      <= gameready_d;
            ingame         <= ingame_d;
            gamelost       <= gamelost_d;
            gamewon        <= gamewon_d;
            opp_alive      <= ~lost_seen_d;
        end
    end

endmodule

// File: tb/tb_match_session_fsm.sv
// Self-checking bench for match_session_fsm with three opponents and short timeouts.
module tb_match_session_fsm;

    localparam int unsigned N = 3;

    localparam int TS_IDLE    = 0;
    localparam int TS_READY   = 1;
    localparam int TS_IN_GAME = 2;
    localparam int TS_LOST    = 3;
    localparam int TS_WON     = 4;

    logic         clk = 1'b0;
    logic         rst_l;
    logic         player_ready, player_unready, top_out;
    logic [N-1:0] ack_received, opp_lost;
    logic         send_ready, send_game_lost, game_active;
    logic         gameready, ingame, gamelost, gamewon;
    logic [N-1:0] opp_alive;
    logic         ready_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic         rdy;
        logic         unrdy;
        logic         top;
        logic [N-1:0] ack;
        logic [N-1:0] lost;
        int           st;
        logic [N-1:0] alive;
        logic         rto;
    } vec_t;

    vec_t tbl[16];

    match_session_fsm #(
        .N_OPP                (N),
        .READY_TIMEOUT_CYCLES (8),
        .LOST_TIMEOUT_CYCLES  (6),
        .WIN_TIMEOUT_CYCLES   (4)
    ) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .player_ready   (player_ready),
        .player_unready (player_unready),
        .top_out        (top_out),
        .ack_received   (ack_received),
        .opp_lost       (opp_lost),
        .send_ready     (send_ready),
        .send_game_lost (send_game_lost),
        .game_active    (game_active),
        .gameready      (gameready),
        .ingame         (ingame),
        .gamelost       (gamelost),
        .gamewon        (gamewon),
        .opp_alive      (opp_alive),
        .ready_timeout  (ready_timeout)
    );

    always #5 clk = ~clk;

    // Expected output word: {active, ready, ingame, lost, won, send_ready, send_lost, alive, rto}.
    function automatic logic [10:0] exp_word(int st, logic [N-1:0] alive, logic rto);
        logic [6:0] f;
        case (st)
            TS_READY:   f = 7'b1100010;
            TS_IN_GAME: f = 7'b1010000;
            TS_LOST:    f = 7'b1001001;
            TS_WON:     f = 7'b1000110;
            default:    f = 7'b0000000;
        endcase
        return {f, alive, rto};
    endfunction

    task automatic compare();
        logic [10:0] act, e;
        string       nm;
        act = {game_active, gameready, ingame, gamelost, gamewon,
               send_ready, send_game_lost, opp_alive, ready_timeout};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %b required an expected entry", act);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", nm, act, e);
            end
        end
    endtask

    task automatic push_exp(int st, logic [N-1:0] alive, logic rto, string nm);
        exp_q.push_back(exp_word(st, alive, rto));
        name_q.push_back(nm);
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, check after the edge.
    task automatic step(logic rdy, logic unrdy, logic top, logic [N-1:0] ack, logic [N-1:0] lost,
                        int st, logic [N-1:0] alive, logic rto, string nm);
        @(negedge clk);
        player_ready   = rdy;
        player_unready = unrdy;
        top_out        = top;
        ack_received   = ack;
        opp_lost       = lost;
        push_exp(st, alive, rto, nm);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle_in(int st, logic [N-1:0] alive, logic rto, string nm);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, st, alive, rto, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // rdy unrdy top  ack     lost    state       alive   rto
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, TS_READY,   3'b111, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'b001, 3'b000, TS_READY,   3'b111, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'b100, 3'b000, TS_READY,   3'b111, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'b010, 3'b000, TS_IN_GAME, 3'b111, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b001, TS_IN_GAME, 3'b110, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 3'b000, 3'b110, TS_WON,     3'b000, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, TS_WON,     3'b000, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'b111, 3'b000, TS_WON,     3'b000, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, TS_WON,     3'b000, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, TS_IDLE,    3'b000, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, TS_READY,   3'b111, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 3'b111, 3'b000, TS_IN_GAME, 3'b111, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b001, TS_IN_GAME, 3'b110, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 3'b000, 3'b000, TS_LOST,    3'b110, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 3'b010, 3'b000, TS_LOST,    3'b110, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 3'b100, 3'b000, TS_IDLE,    3'b110, 1'b0};

        rst_l          = 1'b0;
        player_ready   = 1'b0;
        player_unready = 1'b0;
        top_out        = 1'b0;
        ack_received   = '0;
        opp_lost       = '0;
        #12;
        push_exp(TS_IDLE, 3'b111, 1'b0, "reset_state");
        compare();
        @(negedge clk);
        rst_l = 1'b1;
        idle_in(TS_IDLE, 3'b111, 1'b0, "idle_hold");

        // Staggered ACKs, sticky loss, win priority, 4-cycle win, lost exit via loss+ACK.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rdy, tbl[i].unrdy, tbl[i].top, tbl[i].ack, tbl[i].lost,
                 tbl[i].st, tbl[i].alive, tbl[i].rto, $sformatf("tbl%0d", i));
        end

        // ACKs present in IDLE alongside player_ready are not remembered.
        step(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, TS_READY, 3'b111, 1'b0, "stale_ack_enter");
        idle_in(TS_READY, 3'b111, 1'b0, "stale_ack_ignored");
        step(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, TS_IN_GAME, 3'b111, 1'b0, "fresh_ack_start");

        // Lost phase with no ACKs lasts exactly 6 cycles.
        step(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, TS_LOST, 3'b111, 1'b0, "lost_enter");
        for (int k = 0; k < 5; k++) idle_in(TS_LOST, 3'b111, 1'b0, $sformatf("lost_wait%0d", k));
        idle_in(TS_IDLE, 3'b111, 1'b0, "lost_timeout_exit");

        // Ready phase with a partial ACK lasts exactly 8 cycles then pulses ready_timeout.
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, TS_READY, 3'b111, 1'b0, "rto_enter");
        step(1'b0, 1'b0, 1'b0, 3'b001, 3'b000, TS_READY, 3'b111, 1'b0, "rto_ack0");
        for (int k = 0; k < 6; k++) idle_in(TS_READY, 3'b111, 1'b0, $sformatf("rto_wait%0d", k));
        idle_in(TS_IDLE, 3'b111, 1'b1, "rto_pulse");
        idle_in(TS_IDLE, 3'b111, 1'b0, "rto_pulse_end");

        // Cancel at the third ready cycle; unready beats a full ACK set, no pulse.
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, TS_READY, 3'b111, 1'b0, "unrdy_enter");
        idle_in(TS_READY, 3'b111, 1'b0, "unrdy_wait0");
        idle_in(TS_READY, 3'b111, 1'b0, "unrdy_wait1");
        step(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, TS_IDLE, 3'b111, 1'b0, "unrdy_cancel");
        idle_in(TS_IDLE, 3'b111, 1'b0, "unrdy_no_pulse");

        // Asynchronous reset in the middle of a game.
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, TS_READY, 3'b111, 1'b0, "rst_seq_ready");
        step(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, TS_IN_GAME, 3'b111, 1'b0, "rst_seq_ingame");
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b010, TS_IN_GAME, 3'b101, 1'b0, "rst_seq_lost1");
        @(negedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        push_exp(TS_IDLE, 3'b111, 1'b0, "async_reset_midgame");
        compare();
        @(posedge clk);
        #1;
        push_exp(TS_IDLE, 3'b111, 1'b0, "reset_held");
        compare();
        @(negedge clk);
        rst_l = 1'b1;
        idle_in(TS_IDLE, 3'b111, 1'b0, "post_reset_idle");
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, TS_READY, 3'b111, 1'b0, "post_reset_ready");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
